// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the multicycle ALU.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_MUL   = 4'd10;
  localparam logic [3:0] ALU_MULHU = 4'd11;
  localparam logic [3:0] ALU_DIVU  = 4'd12;
  localparam logic [3:0] ALU_REMU  = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide datapath.
// One step per clock after go_i; result_o shows the value the current step
// produces, so the owner captures it on the edge where last_o is high.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             last_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  // acc holds {high, low}: product for mul, {remainder, quotient} for div
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   operand_q, operand_d;  // multiplicand or divisor
  logic [CW-1:0]      count_q, count_d;
  logic               is_div_q, is_div_d;
  logic               hi_q, hi_d;            // select high half as result

  logic               op_is_div;
  logic               op_is_hi;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;

  assign op_is_div = (op_i == OP_W'(ALU_DIVU)) || (op_i == OP_W'(ALU_REMU));
  assign op_is_hi  = (op_i == OP_W'(ALU_MULHU)) || (op_i == OP_W'(ALU_REMU));

  // One iteration of shift-add multiply and of restoring divide
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                {1'b0, (acc_q[0] ? operand_q : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, operand_q});
    if (div_ge) begin
      div_rem = div_shift[WIDTH-1:0] - operand_q;
    end else begin
      div_rem = div_shift[WIDTH-1:0];
    end
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
    step_next = is_div_q ? div_next : mul_next;
  end

  // Load operands on go, otherwise advance one step while count is nonzero
  always_comb begin
    acc_d     = acc_q;
    operand_d = operand_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    if (go_i) begin
      is_div_d  = op_is_div;
      hi_d      = op_is_hi;
      operand_d = op_is_div ? b_i : a_i;
      acc_d     = {{WIDTH{1'b0}}, (op_is_div ? a_i : b_i)};
      count_d   = CNT_FULL;
    end else if (count_q != CNT_ZERO) begin
      acc_d   = step_next;
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = CNT_ZERO;
    end
  end

  // Datapath registers; reset only needs to clear the step counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= {(2*WIDTH){1'b0}};
      operand_q <= {WIDTH{1'b0}};
      count_q   <= CNT_ZERO;
      is_div_q  <= 1'b0;
      hi_q      <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      operand_q <= operand_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
    end
  end

  assign busy_o   = (count_q != CNT_ZERO);
  assign last_o   = (count_q == CNT_ONE);
  assign result_o = hi_q ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/shift/compare ops plus iterative
// MUL/MULHU/DIVU/REMU behind a start/ready/done handshake.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [OP_W-1:0]  ALU_Operation_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             ready_o,
  output logic             done_o,
  output logic             Zero_o,
  output logic [WIDTH-1:0] ALU_Result_o
);

  localparam int SHW = $clog2(WIDTH);

  function automatic logic is_iterative(input logic [OP_W-1:0] op);
    return (op == OP_W'(ALU_MUL))  || (op == OP_W'(ALU_MULHU)) ||
           (op == OP_W'(ALU_DIVU)) || (op == OP_W'(ALU_REMU));
  endfunction

  function automatic logic [WIDTH-1:0] single_op(input logic [OP_W-1:0]  op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_W'(ALU_ADD):  single_op = a + b;
      OP_W'(ALU_SUB):  single_op = a - b;
      OP_W'(ALU_AND):  single_op = a & b;
      OP_W'(ALU_OR):   single_op = a | b;
      OP_W'(ALU_XOR):  single_op = a ^ b;
      OP_W'(ALU_SLL):  single_op = a << sh;
      OP_W'(ALU_SRL):  single_op = a >> sh;
      OP_W'(ALU_SRA):  single_op = $unsigned($signed(a) >>> sh);
      OP_W'(ALU_SLT):  single_op = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_W'(ALU_SLTU): single_op = {{(WIDTH-1){1'b0}}, (a < b)};
      default:         single_op = {WIDTH{1'b0}};
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic             accept;
  logic             md_go;
  logic             md_busy;
  logic             md_last;
  logic [WIDTH-1:0] md_result;
  logic [WIDTH-1:0] sc_result;

  assign accept    = start_i && ready_q;
  assign sc_result = single_op(ALU_Operation_i, A_i, B_i);

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .OP_W  (OP_W)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .go_i     (md_go),
    .op_i     (ALU_Operation_i),
    .a_i      (A_i),
    .b_i      (B_i),
    .busy_o   (md_busy),
    .last_o   (md_last),
    .result_o (md_result)
  );

  // Next state, result capture and handshake flags
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    md_go    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (is_iterative(ALU_Operation_i)) begin
            md_go   = 1'b1;
            state_d = S_BUSY;
          end else begin
            state_d  = S_DONE;
            result_d = sc_result;
            zero_d   = (sc_result == {WIDTH{1'b0}});
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (md_last) begin
          state_d  = S_DONE;
          result_d = md_result;
          zero_d   = (md_result == {WIDTH{1'b0}});
        end else if (md_busy) begin
          state_d = S_BUSY;
        end else begin
          // datapath lost its count: recover to idle rather than hang
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d != S_BUSY);
    done_d  = (state_d == S_DONE);
  end

  // State, result and handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign ready_o      = ready_q;
  assign done_o       = done_q;
  assign Zero_o       = zero_q;
  assign ALU_Result_o = result_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): transaction-level
// reference model checked every cycle, plus directed literal vectors.
module tb_alu_multicycle;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          start_i;
  logic [3:0]    ALU_Operation_i;
  logic [W-1:0]  A_i;
  logic [W-1:0]  B_i;
  logic          ready_o;
  logic          done_o;
  logic          Zero_o;
  logic [W-1:0]  ALU_Result_o;

  int errors = 0;
  int checks = 0;

  alu_multicycle #(.WIDTH(W), .OP_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .ALU_Operation_i (ALU_Operation_i),
    .A_i             (A_i),
    .B_i             (B_i),
    .ready_o         (ready_o),
    .done_o          (done_o),
    .Zero_o          (Zero_o),
    .ALU_Result_o    (ALU_Result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from the operation definitions, using 64-bit math
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  ref_alu = a + b;
      4'd1:  ref_alu = a - b;
      4'd2:  ref_alu = a & b;
      4'd3:  ref_alu = a | b;
      4'd4:  ref_alu = a ^ b;
      4'd5:  ref_alu = a << b[4:0];
      4'd6:  ref_alu = a >> b[4:0];
      4'd7:  ref_alu = $unsigned($signed(a) >>> b[4:0]);
      4'd8:  ref_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  ref_alu = (a < b) ? 32'd1 : 32'd0;
      4'd10: ref_alu = p[31:0];
      4'd11: ref_alu = p[63:32];
      4'd12: ref_alu = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd13: ref_alu = (b == 32'd0) ? a : a % b;
      default: ref_alu = 32'd0;
    endcase
  endfunction

  // Model state: expected outputs after each rising edge
  logic         m_valid = 1'b0;
  logic         m_ready, m_done, m_zero, m_pending;
  logic [W-1:0] m_result, m_pend_res;
  int           m_edge = 0;
  int           m_done_edge = 0;

  // Transaction model: an accepted op finishes 0 or W edges later
  always @(posedge clk) begin : model_p
    int           e, de;
    logic         pend, dn, acc;
    logic [W-1:0] pr;
    e    = m_edge + 1;
    de   = m_done_edge;
    pend = m_pending;
    pr   = m_pend_res;
    m_edge <= e;
    if (reset) begin
      m_valid   <= 1'b1;
      m_pending <= 1'b0;
      m_ready   <= 1'b1;
      m_done    <= 1'b0;
      m_result  <= 32'd0;
      m_zero    <= 1'b1;
    end else begin
      acc = start_i && m_ready;
      if (acc) begin
        pend = 1'b1;
        de   = e + ((ALU_Operation_i >= 4'd10 && ALU_Operation_i <= 4'd13) ? W : 0);
        pr   = ref_alu(ALU_Operation_i, A_i, B_i);
      end
      dn = pend && (e == de);
      if (dn) begin
        m_result <= pr;
        m_zero   <= (pr == 32'd0);
        pend = 1'b0;
      end
      m_done      <= dn;
      m_pending   <= pend;
      m_done_edge <= de;
      m_pend_res  <= pr;
      m_ready     <= !pend;
    end
  end

  // Compare process: every cycle after reset, on the falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ready_o", {31'd0, ready_o}, {31'd0, m_ready});
      chk("done_o",  {31'd0, done_o},  {31'd0, m_done});
      chk("result",  ALU_Result_o,     m_result);
      chk("Zero_o",  {31'd0, Zero_o},  {31'd0, m_zero});
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic z, output int lat,
                        output int rlow);
    @(negedge clk);
    start_i = 1'b1; ALU_Operation_i = op; A_i = a; B_i = b;
    @(negedge clk);
    start_i = 1'b0;
    lat = 0; rlow = 0;
    while (!done_o && lat < 100) begin
      if (!ready_o) rlow++;
      @(negedge clk);
      lat++;
    end
    if (!done_o) begin
      checks++; errors++;
      $display("FAIL timeout: op %0d no done_o within 100 cycles", op);
    end
    res = ALU_Result_o;
    z   = Zero_o;
  endtask

  task automatic vec(input string name, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
    logic [W-1:0] r;
    logic z;
    int lat, rlow;
    run_op(op, a, b, r, z, lat, rlow);
    chk({name, "_res"},  r, exp);
    chk({name, "_zero"}, {31'd0, z}, (exp == 32'd0) ? 32'd1 : 32'd0);
    chk({name, "_lat"},  lat, exp_lat);
    chk({name, "_rlow"}, rlow, exp_lat);
  endtask

  initial begin
    int dn_cnt;
    reset = 1'b1; start_i = 1'b0; ALU_Operation_i = 4'd0; A_i = 32'd0; B_i = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_done",  {31'd0, done_o},  32'd0);
    chk("rst_res",   ALU_Result_o,     32'd0);
    chk("rst_zero",  {31'd0, Zero_o},  32'd1);
    reset = 1'b0;

    vec("add",   4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0);
    vec("sub",   4'd1,  32'd5,         32'd5,         32'h0000_0000, 0);
    vec("and",   4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0);
    vec("or",    4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0);
    vec("xor",   4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
    vec("sll",   4'd5,  32'h0000_0001, 32'h0000_0023, 32'h0000_0008, 0);
    vec("srl",   4'd6,  32'h8000_0000, 32'd31,        32'h0000_0001, 0);
    vec("sra",   4'd7,  32'hF000_0000, 32'd4,         32'hFF00_0000, 0);
    vec("slt",   4'd8,  32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 0);
    vec("sltu",  4'd9,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 0);
    vec("op14",  4'd14, 32'd5,         32'd6,         32'h0000_0000, 0);
    vec("op15",  4'd15, 32'd5,         32'd6,         32'h0000_0000, 0);
    vec("mul",   4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, W);
    vec("mulhu", 4'd11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, W);
    vec("mulm",  4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, W);
    vec("mulhm", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, W);
    vec("divu",  4'd12, 32'd100,       32'd7,         32'd14,        W);
    vec("remu",  4'd13, 32'd100,       32'd7,         32'd2,         W);
    vec("div0",  4'd12, 32'd12345,     32'd0,         32'hFFFF_FFFF, W);
    vec("rem0",  4'd13, 32'd9,         32'd0,         32'd9,         W);
    vec("divs",  4'd12, 32'd5,         32'd9,         32'd0,         W);
    vec("rems",  4'd13, 32'd5,         32'd9,         32'd5,         W);
    vec("divm",  4'd12, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, W);

    // back-to-back single-cycle ops: done_o every cycle
    @(negedge clk);
    start_i = 1'b1; ALU_Operation_i = 4'd0; A_i = 32'd1; B_i = 32'd2;
    @(negedge clk);
    chk("b2b_done0", {31'd0, done_o}, 32'd1);
    chk("b2b_res0",  ALU_Result_o, 32'd3);
    ALU_Operation_i = 4'd1; A_i = 32'd10; B_i = 32'd3;
    @(negedge clk);
    chk("b2b_done1", {31'd0, done_o}, 32'd1);
    chk("b2b_res1",  ALU_Result_o, 32'd7);
    ALU_Operation_i = 4'd4; A_i = 32'hAAAA_5555; B_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("b2b_done2", {31'd0, done_o}, 32'd1);
    chk("b2b_res2",  ALU_Result_o, 32'h5555_AAAA);
    start_i = 1'b0;
    @(negedge clk);
    chk("b2b_idle", {31'd0, done_o}, 32'd0);

    // start held through BUSY with new operands: ignored, then accepted in DONE
    start_i = 1'b1; ALU_Operation_i = 4'd12; A_i = 32'd100; B_i = 32'd7;
    @(negedge clk);
    ALU_Operation_i = 4'd0; A_i = 32'd1; B_i = 32'd2;
    dn_cnt = 0;
    while (!done_o && dn_cnt < 100) begin
      @(negedge clk);
      dn_cnt++;
    end
    chk("hold_lat", dn_cnt, W);
    chk("hold_res", ALU_Result_o, 32'd14);
    @(negedge clk);
    chk("hold_b2b_done", {31'd0, done_o}, 32'd1);
    chk("hold_b2b_res",  ALU_Result_o, 32'd3);
    start_i = 1'b0;

    // reset during step 10 of DIVU aborts with no done_o
    @(negedge clk);
    start_i = 1'b1; ALU_Operation_i = 4'd12; A_i = 32'd1000; B_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy", {31'd0, ready_o}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", {31'd0, ready_o}, 32'd1);
    chk("abort_done",  {31'd0, done_o},  32'd0);
    chk("abort_res",   ALU_Result_o,     32'd0);
    chk("abort_zero",  {31'd0, Zero_o},  32'd1);
    dn_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) dn_cnt++;
    end
    chk("abort_no_done", dn_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
